// File: rtl/pc_branch_unit.sv
// Fetch-stage program counter with N branch-target registers, signed-offset
// target writes, conditional/unconditional jumps and a call/return stack.
module pc_branch_unit #(
  parameter int L      = 10,
  parameter int NTGT   = 3,
  parameter int OFFW   = 8,
  parameter int SDEPTH = 4,
  parameter int SELW   = $clog2(NTGT + 1)
) (
  input  logic            Clk,
  input  logic            ResetN,
  input  logic            Start,
  input  logic            Stall,
  input  logic            JmpEq,
  input  logic            JmpNe,
  input  logic            JmpAl,
  input  logic            Call,
  input  logic            Ret,
  input  logic            SetTgt,
  input  logic            OffsetEn,
  input  logic [SELW-1:0] TgtSel,
  input  logic [OFFW-1:0] Offset,
  input  logic            Zero,
  output logic [L-1:0]    ProgCtr,
  output logic            Taken,
  output logic            StackOvf,
  output logic            StackUnf
);

  localparam int SPW = $clog2(SDEPTH + 1);

  logic [L-1:0]   pc_q, pc_d;
  logic [L-1:0]   tgt_q [NTGT];
  logic [L-1:0]   stk_q [SDEPTH];
  logic [SPW-1:0] sp_q, sp_d;
  logic           zreg_q, zreg_d;
  logic           taken_q, taken_d;
  logic           ovf_q, ovf_d;
  logic           unf_q, unf_d;

  logic           sel_ok;
  logic [L-1:0]   sel_tgt;
  logic [L-1:0]   stk_top;
  logic [L-1:0]   pc_inc;
  logic [L-1:0]   pc_off;
  logic           tgt_we;
  logic           push;
  logic           any_jump;
  logic           cond_hit;

  assign pc_inc   = pc_q + L'(1);
  assign pc_off   = pc_q + L'($signed(Offset));
  assign any_jump = Call | JmpAl | JmpEq | JmpNe;
  assign cond_hit = (JmpEq & zreg_q) | (JmpNe & ~zreg_q);

  // Selects above NTGT never match any entry, so they behave like select 0.
  always_comb begin
    sel_ok  = 1'b0;
    sel_tgt = '0;
    for (int i = 0; i < NTGT; i++) begin
      if (TgtSel == SELW'(i + 1)) begin
        sel_ok  = 1'b1;
        sel_tgt = tgt_q[i];
      end
    end
    stk_top = '0;
    for (int i = 0; i < SDEPTH; i++) begin
      if (sp_q == SPW'(i + 1)) stk_top = stk_q[i];
    end
  end

  always_comb begin
    pc_d    = pc_q;
    sp_d    = sp_q;
    zreg_d  = zreg_q;
    taken_d = 1'b0;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    tgt_we  = 1'b0;
    push    = 1'b0;
    if (!Stall) begin
      zreg_d = Zero;
      if (Start) begin
        pc_d = '0;
        sp_d = '0;
      end else if (Ret) begin
        if (sp_q != '0) begin
          pc_d    = stk_top;
          sp_d    = sp_q - SPW'(1);
          taken_d = 1'b1;
        end else begin
          pc_d  = pc_inc;
          unf_d = 1'b1;
        end
      end else if (Call && sel_ok) begin
        pc_d    = sel_tgt;
        taken_d = 1'b1;
        if (sp_q != SPW'(SDEPTH)) begin
          push = 1'b1;
          sp_d = sp_q + SPW'(1);
        end else begin
          ovf_d = 1'b1;
        end
      end else if ((JmpAl || cond_hit) && sel_ok) begin
        pc_d    = sel_tgt;
        taken_d = 1'b1;
      end else begin
        pc_d   = pc_inc;
        // A jump request that fell through still blocks the target write.
        tgt_we = SetTgt && sel_ok && !any_jump;
      end
    end
  end

  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      pc_q    <= '0;
      sp_q    <= '0;
      zreg_q  <= 1'b0;
      taken_q <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      sp_q    <= sp_d;
      zreg_q  <= zreg_d;
      taken_q <= taken_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      for (int i = 0; i < NTGT; i++) tgt_q[i] <= '0;
      for (int i = 0; i < SDEPTH; i++) stk_q[i] <= '0;
    end else begin
      for (int i = 0; i < NTGT; i++) begin
        if (tgt_we && TgtSel == SELW'(i + 1)) tgt_q[i] <= OffsetEn ? pc_off : pc_q;
      end
      for (int i = 0; i < SDEPTH; i++) begin
        if (push && sp_q == SPW'(i)) stk_q[i] <= pc_inc;
      end
    end
  end

  assign ProgCtr  = pc_q;
  assign Taken    = taken_q;
  assign StackOvf = ovf_q;
  assign StackUnf = unf_q;

endmodule

// File: tb/tb_pc_branch_unit.sv
// Scoreboard bench for pc_branch_unit: stimulus pushes the reference model's
// expected outputs per edge, a monitor pops and compares after each edge.
module tb_pc_branch_unit;

  localparam int L      = 10;
  localparam int NTGT   = 5;
  localparam int OFFW   = 8;
  localparam int SDEPTH = 4;
  localparam int SELW   = $clog2(NTGT + 1);
  localparam int MODV   = 1 << L;

  logic            Clk = 1'b0;
  logic            ResetN;
  logic            Start, Stall, JmpEq, JmpNe, JmpAl, Call, Ret, SetTgt, OffsetEn, Zero;
  logic [SELW-1:0] TgtSel;
  logic [OFFW-1:0] Offset;
  logic [L-1:0]    ProgCtr;
  logic            Taken, StackOvf, StackUnf;

  pc_branch_unit #(.L(L), .NTGT(NTGT), .OFFW(OFFW), .SDEPTH(SDEPTH)) dut (
    .Clk(Clk), .ResetN(ResetN), .Start(Start), .Stall(Stall),
    .JmpEq(JmpEq), .JmpNe(JmpNe), .JmpAl(JmpAl), .Call(Call), .Ret(Ret),
    .SetTgt(SetTgt), .OffsetEn(OffsetEn), .TgtSel(TgtSel), .Offset(Offset),
    .Zero(Zero), .ProgCtr(ProgCtr), .Taken(Taken),
    .StackOvf(StackOvf), .StackUnf(StackUnf)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic [L-1:0] pc;
    logic         taken;
    logic         ovf;
    logic         unf;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   txn    = 0;

  // Reference model state
  int m_pc;
  int m_tgt[NTGT];
  int m_stk[$];
  bit m_z, m_taken, m_ovf, m_unf;

  task automatic model_reset();
    m_pc = 0;
    foreach (m_tgt[i]) m_tgt[i] = 0;
    m_stk.delete();
    m_z = 0; m_taken = 0; m_ovf = 0; m_unf = 0;
  endtask

  task automatic idle();
    Start = 0; Stall = 0; JmpEq = 0; JmpNe = 0; JmpAl = 0; Call = 0; Ret = 0;
    SetTgt = 0; OffsetEn = 0; TgtSel = '0; Offset = '0; Zero = 0;
  endtask

  // Apply the current inputs for one edge: advance the model, queue the result.
  task automatic tick();
    exp_t e;
    int   inc, sel, off;
    bit   sv;
    if (!ResetN) begin
      model_reset();
    end else if (Stall) begin
      m_taken = 0;
    end else begin
      inc = (m_pc + 1) % MODV;
      sel = int'(TgtSel);
      sv  = (sel >= 1) && (sel <= NTGT);
      off = int'($signed(Offset));
      if (Start) begin
        m_pc = 0; m_stk.delete(); m_taken = 0;
      end else if (Ret) begin
        if (m_stk.size() > 0) begin
          m_pc = m_stk.pop_back(); m_taken = 1;
        end else begin
          m_pc = inc; m_unf = 1; m_taken = 0;
        end
      end else if (Call && sv) begin
        if (m_stk.size() < SDEPTH) m_stk.push_back(inc);
        else m_ovf = 1;
        m_pc = m_tgt[sel-1]; m_taken = 1;
      end else if ((JmpAl || (JmpEq && m_z) || (JmpNe && !m_z)) && sv) begin
        m_pc = m_tgt[sel-1]; m_taken = 1;
      end else begin
        if (SetTgt && sv && !(Call || JmpAl || JmpEq || JmpNe))
          m_tgt[sel-1] = OffsetEn ? ((m_pc + off + MODV) % MODV) : m_pc;
        m_pc = inc; m_taken = 0;
      end
      m_z = Zero;
    end
    e.pc = L'(m_pc); e.taken = m_taken; e.ovf = m_ovf; e.unf = m_unf;
    exp_q.push_back(e);
    @(negedge Clk);
  endtask

  // Drop ResetN between edges and check the outputs clear without a clock.
  task automatic async_reset();
    #2 ResetN = 0;
    #1;
    checks++;
    if (ProgCtr !== '0 || Taken !== 1'b0 || StackOvf !== 1'b0 || StackUnf !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: got pc=%0d taken=%b ovf=%b unf=%b, need all 0",
               ProgCtr, Taken, StackOvf, StackUnf);
    end
    model_reset();
    idle();
    tick();
    ResetN = 1;
  endtask

  // Monitor: the DUT presents a new output after every edge
  initial begin
    exp_t e, a;
    forever begin
      @(posedge Clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a.pc = ProgCtr; a.taken = Taken; a.ovf = StackOvf; a.unf = StackUnf;
        checks++;
        txn++;
        if (a !== e) begin
          errors++;
          $display("FAIL txn%0d: got pc=%0d taken=%b ovf=%b unf=%b, need pc=%0d taken=%b ovf=%b unf=%b",
                   txn, a.pc, a.taken, a.ovf, a.unf, e.pc, e.taken, e.ovf, e.unf);
        end else begin
          $display("txn%0d pc=%0d taken=%b ovf=%b unf=%b ok", txn, a.pc, a.taken, a.ovf, a.unf);
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    ResetN = 0;
    idle();
    model_reset();
    @(negedge Clk);
    tick(); tick();
    ResetN = 1;

    // Free run then stall
    repeat (5) tick();
    Stall = 1; tick(); tick(); Stall = 0;

    // Offset target write (negative offset) then unconditional jump to it
    SetTgt = 1; TgtSel = 2; OffsetEn = 1; Offset = 8'hFD; tick(); idle();
    tick();
    JmpAl = 1; TgtSel = 2; tick(); idle();
    tick();

    // Target 1 via positive offset, then conditional jumps on registered zero
    SetTgt = 1; TgtSel = 1; OffsetEn = 1; Offset = 8'd17; tick(); idle();
    Zero = 1; tick(); idle();
    JmpEq = 1; TgtSel = 1; tick(); idle();
    Zero = 0; tick(); idle();
    JmpEq = 1; TgtSel = 1; tick(); idle();
    JmpNe = 1; TgtSel = 1; tick(); idle();

    // Target 3 for nested calls; five calls overflow a depth-4 stack
    SetTgt = 1; TgtSel = 3; OffsetEn = 1; Offset = 8'd40; tick(); idle();
    for (int i = 0; i < 5; i++) begin
      Call = 1; TgtSel = SELW'((i % 3) + 1); tick(); idle();
      tick();
    end
    for (int i = 0; i < 5; i++) begin
      Ret = 1; tick(); idle();
    end

    // Wrap: target = 0 - 1, jump to 1023, Ret on empty wraps to 0
    Start = 1; tick(); idle();
    SetTgt = 1; TgtSel = 3; OffsetEn = 1; Offset = 8'hFF; tick(); idle();
    JmpAl = 1; TgtSel = 3; tick(); idle();
    Ret = 1; tick(); idle();
    Start = 1; tick(); idle();
    tick();

    // Out-of-range selects fall through; no push on call
    JmpAl = 1; TgtSel = 3'd7; tick(); idle();
    Call = 1; TgtSel = 3'd6; tick(); idle();
    SetTgt = 1; TgtSel = 3'd6; tick(); idle();
    Ret = 1; tick(); idle();

    // Async reset with two return addresses on the stack
    Call = 1; TgtSel = 1; tick(); idle();
    Call = 1; TgtSel = 2; tick(); idle();
    async_reset();
    tick();
    Ret = 1; tick(); idle();

    // Randomised traffic
    for (int n = 0; n < 400; n++) begin
      idle();
      Start    = ($urandom_range(0, 99) < 3);
      Stall    = ($urandom_range(0, 99) < 10);
      Ret      = ($urandom_range(0, 99) < 12);
      Call     = ($urandom_range(0, 99) < 12);
      JmpAl    = ($urandom_range(0, 99) < 8);
      JmpEq    = ($urandom_range(0, 99) < 10);
      JmpNe    = ($urandom_range(0, 99) < 10);
      SetTgt   = ($urandom_range(0, 99) < 30);
      OffsetEn = $urandom_range(0, 1);
      TgtSel   = SELW'($urandom_range(0, (1 << SELW) - 1));
      Offset   = OFFW'($urandom);
      Zero     = $urandom_range(0, 1);
      if (n == 200) begin
        idle();
        async_reset();
      end else begin
        tick();
      end
    end
    idle();
    tick();
    @(negedge Clk);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected results left unchecked, need 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
